// File: rtl/morse_symbol_player_pkg.sv
// rtl/morse_symbol_player_pkg.sv - shared types, unit counts and select decoders
//
// Purpose: symbol-code and FSM state enums, the unit-count constants behind the
// long/short/space selects, and the decode functions that map a select value to
// a 5-bit unit count.
// Ports: none (package).
package morse_pkg;

  typedef enum logic [1:0] {
    SYM_DOT  = 2'b00,
    SYM_DASH = 2'b01,
    SYM_LGAP = 2'b10,
    SYM_WGAP = 2'b11
  } sym_code_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_TONE  = 2'b01,
    ST_SPACE = 2'b10
  } state_t;

  localparam logic [4:0] LONG_U_A  = 5'd5;
  localparam logic [4:0] LONG_U_B  = 5'd8;
  localparam logic [4:0] LONG_U_C  = 5'd10;
  localparam logic [4:0] SHORT_U_A = 5'd1;
  localparam logic [4:0] SHORT_U_B = 5'd3;
  localparam logic [4:0] SHORT_U_C = 5'd4;
  localparam logic [4:0] SPACE_U_A = 5'd3;
  localparam logic [4:0] SPACE_U_B = 5'd5;

  // Select code 00 is not a legal controller output; it decodes like 01.
  function automatic logic [4:0] long_units(input logic [1:0] sel);
    case (sel)
      2'b10:   return LONG_U_B;
      2'b11:   return LONG_U_C;
      default: return LONG_U_A;
    endcase
  endfunction

  function automatic logic [4:0] short_units(input logic [1:0] sel);
    case (sel)
      2'b10:   return SHORT_U_B;
      2'b11:   return SHORT_U_C;
      default: return SHORT_U_A;
    endcase
  endfunction

  function automatic logic [4:0] space_units(input logic sel);
    return sel ? SPACE_U_B : SPACE_U_A;
  endfunction

endpackage

// File: rtl/morse_symbol_player_if.sv
// rtl/morse_symbol_player_if.sv - symbol request handshake between sequencer and player
//
// Purpose: groups the symbol valid/ready handshake and the completion pulse.
// Signals: sym_valid, sym_code (sequencer -> player);
//          sym_ready, sym_done (player -> sequencer).
// Modports: master = sequencer side, slave = player side.
interface morse_symbol_player_if;
  logic       sym_valid;
  logic [1:0] sym_code;
  logic       sym_ready;
  logic       sym_done;

  modport master (
    output sym_valid,
    output sym_code,
    input  sym_ready,
    input  sym_done
  );

  modport slave (
    input  sym_valid,
    input  sym_code,
    output sym_ready,
    output sym_done
  );
endinterface

// File: rtl/morse_symbol_player_unit_tick_gen.sv
// rtl/morse_symbol_player_unit_tick_gen.sv - time-unit divider with synchronous clear
//
// Purpose: counts TICK_DIV clock cycles and flags the last cycle of each unit.
// Ports: clk, rst (async, active-high), clear (restart the unit on the next
//        cycle), tick (high during the final cycle of every unit).
module unit_tick_gen #(
  parameter int TICK_DIV = 20_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);
  localparam logic [W-1:0] ONE  = W'(1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + ONE;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/morse_symbol_player.sv
// rtl/morse_symbol_player.sv - plays one Morse symbol at a time on a buzzer
//
// Purpose: accepts dot/dash/letter-gap/word-gap symbols, plays N units of gated
// square wave followed by S units of silence, then pulses sym_done.
// Ports: clk, rst (async, active-high); long_sel, short_sel, space_sel (duration
//        selects, latched on accept); stop (sync abort); sym (slave handshake:
//        sym_valid, sym_code, sym_ready, sym_done); busy; buzzer.
module morse_symbol_player
  import morse_pkg::*;
#(
  parameter int TICK_DIV = 20_000_000,
  parameter int TONE_DIV = 25_000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  long_sel,
  input  logic [1:0]                  short_sel,
  input  logic                        space_sel,
  input  logic                        stop,
  morse_symbol_player_if.slave        sym,
  output logic                        busy,
  output logic                        buzzer
);

  localparam int TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam logic [TW-1:0] TONE_LAST = TW'(TONE_DIV - 1);
  localparam logic [TW-1:0] TONE_ONE  = TW'(1);

  state_t      state, state_next;
  sym_code_t   code_in;
  logic        tick, unit_last, done_next, div_clear;
  logic [4:0]  units, space_len;
  logic [4:0]  tone_units_in, space_units_in, space_base;
  logic [TW-1:0] tone_cnt;

  // Durations for the symbol being offered, captured only on accept.
  always_comb begin
    code_in        = sym_code_t'(sym.sym_code);
    space_base     = space_units(space_sel);
    tone_units_in  = (code_in == SYM_DASH) ? long_units(long_sel) : short_units(short_sel);
    space_units_in = (code_in == SYM_WGAP) ? {space_base[3:0], 1'b0} : space_base;
  end

  assign sym.sym_ready = (state == ST_IDLE) && !stop;
  assign busy          = (state != ST_IDLE);

  // The last tick of the last unit ends the current phase.
  assign unit_last = tick && (units == 5'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    if (stop) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sym.sym_valid) begin
            state_next = (code_in == SYM_DOT || code_in == SYM_DASH) ? ST_TONE : ST_SPACE;
          end
        end
        ST_TONE: begin
          if (unit_last) state_next = ST_SPACE;
        end
        ST_SPACE: begin
          if (unit_last) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Restarting the divider on every state change keeps each phase an exact
  // multiple of TICK_DIV regardless of where the free-running count was.
  assign div_clear = (state_next != state);

  unit_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(div_clear),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      units        <= '0;
      space_len    <= '0;
      sym.sym_done <= 1'b0;
    end else begin
      sym.sym_done <= done_next;
      if (state == ST_IDLE) begin
        if (state_next != ST_IDLE) begin
          units     <= (state_next == ST_TONE) ? tone_units_in : space_units_in;
          space_len <= space_units_in;
        end
      end else if (state == ST_TONE && state_next == ST_SPACE) begin
        units <= space_len;
      end else if (tick && units != 5'd0) begin
        units <= units - 5'd1;
      end
    end
  end

  // Buzzer is registered off the next state so it is already high on the
  // first TONE cycle and already low on the first cycle after leaving TONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buzzer   <= 1'b0;
      tone_cnt <= '0;
    end else if (state_next == ST_TONE) begin
      if (state != ST_TONE) begin
        buzzer   <= 1'b1;
        tone_cnt <= '0;
      end else if (tone_cnt == TONE_LAST) begin
        buzzer   <= ~buzzer;
        tone_cnt <= '0;
      end else begin
        tone_cnt <= tone_cnt + TONE_ONE;
      end
    end else begin
      buzzer   <= 1'b0;
      tone_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_morse_symbol_player.sv
// tb/tb_morse_symbol_player.sv - self-checking bench for morse_symbol_player
module tb_morse_symbol_player;

  localparam int T0 = 4;
  localparam int D0 = 1;
  localparam int T1 = 5;
  localparam int D1 = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] long_sel = 2'b00;
  logic [1:0] short_sel = 2'b00;
  logic       space_sel = 1'b0;
  logic       stop = 1'b0;
  logic       valid = 1'b0;
  logic [1:0] code = 2'b00;
  logic       busy0, buzzer0, busy1, buzzer1;

  morse_symbol_player_if sym0();
  morse_symbol_player_if sym1();

  assign sym0.sym_valid = valid;
  assign sym0.sym_code  = code;
  assign sym1.sym_valid = valid;
  assign sym1.sym_code  = code;

  morse_symbol_player #(.TICK_DIV(T0), .TONE_DIV(D0)) dut0 (
    .clk(clk), .rst(rst), .long_sel(long_sel), .short_sel(short_sel),
    .space_sel(space_sel), .stop(stop), .sym(sym0), .busy(busy0), .buzzer(buzzer0)
  );

  morse_symbol_player #(.TICK_DIV(T1), .TONE_DIV(D1)) dut1 (
    .clk(clk), .rst(rst), .long_sel(long_sel), .short_sel(short_sel),
    .space_sel(space_sel), .stop(stop), .sym(sym1), .busy(busy1), .buzzer(buzzer1)
  );

  always #5 clk = ~clk;

  logic a_rdy[2], a_done[2], a_busy[2], a_buz[2];
  assign a_rdy[0]  = sym0.sym_ready;
  assign a_rdy[1]  = sym1.sym_ready;
  assign a_done[0] = sym0.sym_done;
  assign a_done[1] = sym1.sym_done;
  assign a_busy[0] = busy0;
  assign a_busy[1] = busy1;
  assign a_buz[0]  = buzzer0;
  assign a_buz[1]  = buzzer1;

  int total = 0;
  int bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: each instance is described by the cycle windows of its
  // current symbol. Cycle n is the cycle following the n-th rising edge.
  int tdiv[2] = '{T0, T1};
  int tdv[2]  = '{D0, D1};
  int cyc = 0;
  int tlo[2] = '{0, 0};
  int thi[2] = '{-1, -1};
  int shi[2] = '{-1, -1};
  int dcy[2] = '{-1, -1};

  function automatic int tone_len(input logic [1:0] c, input logic [1:0] ls, input logic [1:0] ss);
    if (c == 2'b01) return (ls == 2'b10) ? 8 : (ls == 2'b11) ? 10 : 5;
    return (ss == 2'b10) ? 3 : (ss == 2'b11) ? 4 : 1;
  endfunction

  function automatic int gap_len(input logic [1:0] c, input logic sp);
    int s;
    s = sp ? 5 : 3;
    return (c == 2'b11) ? 2 * s : s;
  endfunction

  always @(posedge clk) begin
    int k;
    k = cyc;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        tlo[i] = 0; thi[i] = -1; shi[i] = -1; dcy[i] = -1;
      end else if (k > shi[i]) begin
        if (valid && !stop) begin
          int n, s;
          s = gap_len(code, space_sel);
          n = (code[1] == 1'b0) ? tone_len(code, long_sel, short_sel) : 0;
          tlo[i] = k + 1;
          thi[i] = k + n * tdiv[i];
          shi[i] = k + (n + s) * tdiv[i];
          dcy[i] = shi[i] + 1;
        end
      end else if (stop) begin
        if (thi[i] > k) thi[i] = k;
        shi[i] = k;
        dcy[i] = -1;
      end
    end
    cyc = k + 1;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic in_t, in_s, idl, ebz, ed;
      int c;
      c = cyc;
      in_t = !rst && c >= tlo[i] && c <= thi[i];
      in_s = !rst && !in_t && c <= shi[i];
      idl  = !(in_t || in_s);
      ebz  = in_t && (((c - tlo[i]) / tdv[i]) % 2 == 0);
      ed   = !rst && (c == dcy[i]);
      check($sformatf("model_ready%0d", i), 32'(a_rdy[i]), 32'(idl && !stop));
      check($sformatf("model_busy%0d", i), 32'(a_busy[i]), 32'(!idl));
      check($sformatf("model_buzzer%0d", i), 32'(a_buz[i]), 32'(ebz));
      check($sformatf("model_done%0d", i), 32'(a_done[i]), 32'(ed));
    end
  end

  task automatic wait_idle();
    int ok;
    ok = 0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (!busy0 && !busy1) begin
        ok = 1;
        break;
      end
    end
    check("idle_timeout", 32'(ok), 32'd1);
  endtask

  // Offers one symbol, then measures the cycle (relative to accept) of the
  // sym_done pulse and the number of buzzer-high cycles on instance 0.
  task automatic run_sym(input string nm, input logic [1:0] c, input logic [1:0] ls,
                         input logic [1:0] ss, input logic sp, input int exp_done,
                         input int exp_high, input int chg_at);
    int highs, dn;
    wait_idle();
    @(posedge clk); #2;
    valid = 1'b1; code = c; long_sel = ls; short_sel = ss; space_sel = sp;
    @(posedge clk); #2;
    valid = 1'b0;
    highs = 0;
    dn = -1;
    for (int n = 1; n < 200; n++) begin
      if (n == chg_at) long_sel = 2'b11;
      @(negedge clk);
      if (n == 1) check({nm, "_first_buzz"}, 32'(buzzer0), 32'(exp_high > 0));
      if (buzzer0) highs++;
      if (sym0.sym_done) begin
        dn = n;
        break;
      end
      @(posedge clk); #2;
    end
    check({nm, "_done_cycle"}, 32'(dn), 32'(exp_done));
    check({nm, "_buzz_highs"}, 32'(highs), 32'(exp_high));
  endtask

  initial begin
    #7;
    check("reset_busy", 32'(busy0), 32'd0);
    check("reset_buzzer", 32'(buzzer0), 32'd0);
    check("reset_done", 32'(sym0.sym_done), 32'd0);
    check("reset_ready", 32'(sym0.sym_ready), 32'd1);
    @(posedge clk); #2;
    rst = 1'b0;

    run_sym("dot_s1", 2'b00, 2'b01, 2'b01, 1'b0, 17, 2, 0);
    run_sym("dash_l11", 2'b01, 2'b11, 2'b01, 1'b1, 61, 20, 0);
    run_sym("dash_l00", 2'b01, 2'b00, 2'b01, 1'b0, 33, 10, 0);
    run_sym("word_gap", 2'b11, 2'b01, 2'b01, 1'b0, 25, 0, 0);
    run_sym("letter_gap", 2'b10, 2'b01, 2'b01, 1'b1, 21, 0, 0);
    run_sym("dash_sel_change", 2'b01, 2'b01, 2'b01, 1'b0, 33, 10, 5);
    run_sym("dot_s11", 2'b00, 2'b01, 2'b11, 1'b1, 37, 8, 0);

    // stop in TONE cycle 3, then stop together with valid in IDLE
    wait_idle();
    @(posedge clk); #2;
    valid = 1'b1; code = 2'b01; long_sel = 2'b01; space_sel = 1'b0;
    @(posedge clk); #2;
    valid = 1'b0;
    @(posedge clk); #2;
    @(posedge clk); #2;
    stop = 1'b1;
    @(negedge clk);
    check("stop_still_tone", 32'(busy0), 32'd1);
    @(posedge clk); #2;
    valid = 1'b1;
    @(negedge clk);
    check("stop_idle", 32'(busy0), 32'd0);
    check("stop_buzzer", 32'(buzzer0), 32'd0);
    check("stop_no_done", 32'(sym0.sym_done), 32'd0);
    check("stop_ready_low", 32'(sym0.sym_ready), 32'd0);
    @(posedge clk); #2;
    stop = 1'b0; valid = 1'b0;
    @(negedge clk);
    check("stop_valid_no_accept", 32'(busy0), 32'd0);
    check("stop_valid_no_done", 32'(sym0.sym_done), 32'd0);

    // rst mid-SPACE, then two dots streamed with valid held high
    wait_idle();
    @(posedge clk); #2;
    valid = 1'b1; code = 2'b00; short_sel = 2'b01; space_sel = 1'b0;
    @(posedge clk); #2;
    valid = 1'b0;
    for (int n = 2; n <= 8; n++) begin
      @(posedge clk); #2;
    end
    rst = 1'b1;
    #1;
    check("rst_async_busy", 32'(busy0), 32'd0);
    check("rst_async_buzzer", 32'(buzzer0), 32'd0);
    check("rst_async_done", 32'(sym0.sym_done), 32'd0);
    check("rst_async_ready", 32'(sym0.sym_ready), 32'd1);
    @(posedge clk); #2;
    rst = 1'b0;
    valid = 1'b1; code = 2'b00;
    @(posedge clk); #2;
    for (int n = 1; n < 17; n++) begin
      @(posedge clk); #2;
    end
    @(negedge clk);
    check("stream_done", 32'(sym0.sym_done), 32'd1);
    check("stream_ready", 32'(sym0.sym_ready), 32'd1);
    @(posedge clk); #2;
    valid = 1'b0;
    @(negedge clk);
    check("stream_second_busy", 32'(busy0), 32'd1);
    check("stream_second_buzz", 32'(buzzer0), 32'd1);
    check("stream_second_nodone", 32'(sym0.sym_done), 32'd0);

    // randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      @(posedge clk); #2;
      valid     = 1'($urandom % 2);
      code      = 2'($urandom);
      long_sel  = 2'($urandom);
      short_sel = 2'($urandom);
      space_sel = 1'($urandom);
      stop      = ($urandom % 24) == 0;
      rst       = ($urandom % 500) == 0;
    end
    @(posedge clk); #2;
    valid = 1'b0; stop = 1'b0; rst = 1'b0;
    wait_idle();
    @(posedge clk); #2;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/morse_symbol_player.md
# morse_symbol_player

Downstream stage of the buzzer duration-select controller. Accepts one Morse symbol at a time over a valid/ready handshake and plays it on the buzzer. Tone and gap lengths come from the controller's long-code, short-code and short-space select outputs, and each select is latched when its symbol is accepted. Output is a gated square wave plus a done pulse for the upstream encoder/sequencer.

## Interface
- `TICK_DIV`, default 20_000_000: clock cycles per 0.2 s time unit; must be ≥ 2.
- `TONE_DIV`, default 25_000: clock cycles per buzzer half-period; must be ≥ 1.
- `clk`  in  1  system clock.
- `rst`  in  1  reset. One clock; reset is asynchronous and active-high.
- `long_sel`  in  2  long-code select (from temp1): 01 = 5 units, 10 = 8 units, 11 = 10 units; 00 is treated as 01.
- `short_sel`  in  2  short-code select (from temp2): 01 = 1 unit, 10 = 3 units, 11 = 4 units; 00 is treated as 01.
- `space_sel`  in  1  short-space select (from temp3): 0 = 3 units, 1 = 5 units.
- `sym_valid`  in  1  symbol request.
- `sym_code`  in  2  symbol code: 00 dot, 01 dash, 10 letter gap, 11 word gap.
- `stop`  in  1  synchronous abort.
- `sym_ready`  out  1  block can accept a symbol; equals IDLE & ~stop.
- `busy`  out  1  state ≠ IDLE.
- `buzzer`  out  1  square-wave drive to the buzzer.
- `sym_done`  out  1  one-cycle pulse when a symbol completes normally.

## Operation
- States are IDLE, TONE and SPACE. All outputs reset to 0, except `sym_ready`, which is 1 when `stop` is 0. State resets to IDLE.
- Accept occurs when `sym_valid & sym_ready` is high at a rising edge. On accept, the block latches `sym_code`, N and S:
  - N is the short-code length for a dot and the long-code length for a dash.
  - S is the short-space length, or 2×S for a word gap.
- A dot or dash goes IDLE→TONE. After N units it goes TONE→SPACE, and after S units it goes SPACE→IDLE.
- A letter gap or word gap goes IDLE→SPACE directly, so it produces silence only.
- Changes on the select inputs after accept have no effect on the symbol in progress.
- The unit tick divider clears on accept, so every unit is exactly TICK_DIV cycles long.
- In TONE, `buzzer` starts at 1 on the first TONE cycle and toggles every TONE_DIV cycles. In IDLE and SPACE, `buzzer` is 0.
- `sym_done` pulses on the SPACE→IDLE transition only.
- `stop` forces IDLE on the next edge from any state. In that case `buzzer` is 0 and no `sym_done` pulse is issued.
- `stop` and `sym_valid` asserted together in IDLE: no accept.
- `rst` mid-symbol: everything clears immediately and the symbol is discarded.
- Unit and tone counters must not wrap inside a state, and they reload on every state entry.

## Timing
- Accept at edge k:
  - TONE occupies cycles k+1 … k+N·TICK_DIV.
  - SPACE occupies cycles k+N·TICK_DIV+1 … k+(N+S)·TICK_DIV.
  - `sym_done` = 1 and `sym_ready` = 1 at cycle k+(N+S)·TICK_DIV+1.
- Gap symbols: SPACE occupies k+1 … k+S·TICK_DIV.
- Back-to-back operation: a new accept is possible in the same cycle as `sym_done`. There are no idle bubbles beyond that one IDLE cycle.
- Latency from accept to the first buzzer high is 1 cycle.

## Structure
- Package `morse_pkg` holds:
  - the symbol-code enum and state enum;
  - unit-count constants (5/8/10, 1/3/4, 3/5);
  - functions `long_units(sel)`, `short_units(sel)` and `space_units(sel)`, each returning a 5-bit count.
- Sub-module `unit_tick_gen`: TICK_DIV divider with synchronous clear, producing a one-cycle tick. Instance it once; the tone divider stays inline.

## Test plan
All cases use TICK_DIV=4 and TONE_DIV=1 unless noted.
- Dot, short_sel=01, space_sel=0, accept at k: `buzzer` toggles each cycle over k+1…k+4, is silent over k+5…k+16, and `sym_done` is high at k+17.
- Dash, long_sel=11, space_sel=1: TONE lasts 40 cycles and SPACE lasts 20, then `sym_done` pulses. With long_sel=00 instead, TONE lasts 20 cycles.
- Word gap, space_sel=0: 24 silent cycles, `buzzer` stays 0 throughout, then `sym_done` pulses. A letter gap with space_sel=1 gives 20 silent cycles.
- Dash accepted with long_sel=01, then long_sel is changed to 11 mid-TONE: TONE still lasts exactly 20 cycles.
- `stop` raised in TONE cycle 3: IDLE on the next cycle, `buzzer` = 0, no `sym_done`. `stop` together with `sym_valid` in IDLE: no accept.
- `rst` pulsed mid-SPACE, then two symbols streamed back-to-back with `sym_valid` held high: all outputs clear asynchronously, and the second accept lands on the `sym_done` cycle.
